// File: rtl/serial_mod_accumulator_if.sv
// Operand and result valid/ready streams for serial_mod_accumulator.
interface serial_mod_accumulator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [7:0]       out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/serial_mod_accumulator.sv
// Bit-serial multi-operand mod-2^WIDTH accumulator: one full-adder slice with a
// registered carry, one operand per WIDTH+1 cycles, frame result on a second stream.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for an operand; in_ready high
// ST_SHIFT | adding op into acc one bit per cycle, LSB first, WIDTH cycles
// ST_OUT   | frame sum and count presented until out_ready
module serial_mod_accumulator #(
  parameter int WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_mod_accumulator_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic             last_q, last_d;

  logic sum_bit;
  logic carry_bit;

  assign sum_bit   = acc_q[0] ^ op_q[0] ^ c_q;
  assign carry_bit = (acc_q[0] & op_q[0]) | (acc_q[0] & c_q) | (op_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_data;
          last_d  = bus.in_last;
          c_d     = 1'b0;
          cnt_d   = '0;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = {sum_bit, acc_q[WIDTH-1:1]};
        op_d  = {1'b0, op_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          // Dropping the MSB carry-out is what makes the sum wrap mod 2^WIDTH.
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = last_q ? ST_OUT : ST_IDLE;
        end else begin
          c_d   = carry_bit;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          count_d = 8'd0;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      count_q <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_serial_mod_accumulator.sv
// Directed self-checking bench for serial_mod_accumulator at WIDTH=32.
module tb_serial_mod_accumulator;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   acc_cyc;
  int   prev_acc_cyc;
  int   lat;

  serial_mod_accumulator_if #(.WIDTH(WIDTH)) bus ();

  serial_mod_accumulator #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present a word and hold it until accepted; records the accept edge cycle.
  task automatic send_word(input logic [31:0] data, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      $display("FAIL send_timeout got=%0d exp=<200", n);
      $fatal(1, "in_ready never rose");
    end
    @(posedge clk);
    prev_acc_cyc = acc_cyc;
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid, optionally driving junk on the input stream meanwhile.
  task automatic wait_out(input bit junk, output int latency);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      if (junk) begin
        bus.in_valid = 1'($urandom);
        bus.in_data  = $urandom;
        bus.in_last  = 1'($urandom);
      end
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL out_timeout got=%0d exp=<200", n);
    end
    latency = cyc - acc_cyc;
  endtask

  task automatic handshake();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] hold_sum;
    logic [7:0]  hold_cnt;
    cyc = 0; n_checks = 0; n_errors = 0; acc_cyc = 0; prev_acc_cyc = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", bus.out_sum, 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);

    // single operand, latency
    send_word(32'hDEADBEEF, 1'b1);
    chk("single_busy_in_ready", 32'(bus.in_ready), 32'd0);
    wait_out(1'b0, lat);
    chk("single_latency", 32'(lat), 32'd32);
    chk("single_sum", bus.out_sum, 32'hDEADBEEF);
    chk("single_count", 32'(bus.out_count), 32'd1);
    handshake();

    // wrap then fresh frame
    send_word(32'hFFFFFFFF, 1'b0);
    send_word(32'h00000001, 1'b1);
    wait_out(1'b0, lat);
    chk("wrap_sum", bus.out_sum, 32'h00000000);
    chk("wrap_count", 32'(bus.out_count), 32'd2);
    handshake();
    send_word(32'h00000005, 1'b1);
    wait_out(1'b0, lat);
    chk("fresh_sum", bus.out_sum, 32'h00000005);
    chk("fresh_count", 32'(bus.out_count), 32'd1);
    handshake();

    // five-term sum with back-to-back accepts
    send_word(32'h5BE0CD19, 1'b0);
    send_word(32'h3587272B, 1'b0);
    chk("five_spacing_1", 32'(acc_cyc - prev_acc_cyc), 32'd33);
    send_word(32'h1F85C98C, 1'b0);
    chk("five_spacing_2", 32'(acc_cyc - prev_acc_cyc), 32'd33);
    send_word(32'h428A2F98, 1'b0);
    send_word(32'h61626380, 1'b1);
    chk("five_spacing_4", 32'(acc_cyc - prev_acc_cyc), 32'd33);
    wait_out(1'b0, lat);
    chk("five_latency", 32'(lat), 32'd32);
    chk("five_sum", bus.out_sum, 32'h54DA50E8);
    chk("five_count", 32'(bus.out_count), 32'd5);

    // output backpressure with a pending input
    hold_sum = bus.out_sum;
    hold_cnt = bus.out_count;
    bus.in_valid = 1'b1; bus.in_data = 32'h12345678; bus.in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_sum", bus.out_sum, 32'h54DA50E8);
      chk("bp_count", 32'(bus.out_count), 32'd5);
    end
    handshake();
    chk("bp_hold_sum_seen", hold_sum, 32'h54DA50E8);
    chk("bp_hold_cnt_seen", 32'(hold_cnt), 32'd5);

    // out_ready while idle must not matter
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_ready_out_valid", 32'(bus.out_valid), 32'd0);

    // junk on the input stream while busy
    send_word(32'h11111111, 1'b0);
    for (int i = 0; i < 31; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom);
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom);
    end
    send_word(32'h22222222, 1'b1);
    wait_out(1'b1, lat);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom);
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom);
    end
    chk("junk_latency", 32'(lat), 32'd32);
    chk("junk_sum", bus.out_sum, 32'h33333333);
    chk("junk_count", 32'(bus.out_count), 32'd2);
    handshake();

    // reset in the middle of the second operand
    send_word(32'h00000010, 1'b0);
    send_word(32'h00000020, 1'b0);
    repeat (17) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_sum", bus.out_sum, 32'd0);
    chk("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send_word(32'h00000007, 1'b1);
    wait_out(1'b0, lat);
    chk("post_rst_sum", bus.out_sum, 32'h00000007);
    chk("post_rst_count", 32'(bus.out_count), 32'd1);
    handshake();

    // 257 operands: count saturates, sum keeps going
    for (int i = 0; i < 257; i++) send_word(32'h00000001, (i == 256));
    wait_out(1'b0, lat);
    chk("sat_sum", bus.out_sum, 32'h00000101);
    chk("sat_count", 32'(bus.out_count), 32'd255);
    handshake();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
